elastic_reg_pipe: RTL and testbench
===================================

Name: elastic_reg_pipe

Overview:
- Parametrised successor to the single-bit level-sensitive storage element: a chain of DEPTH edge-triggered, WIDTH-bit storage stages with valid/ready flow control.
- Adds per-stage occupancy, backpressure, bubble collapsing, synchronous flush and an occupancy count.
- Used as a generic retiming/buffering element between producer and consumer blocks in the datapath.

Parameters:
- WIDTH, 8, data bits per stage (>=1)
- DEPTH, 3, number of register stages (>=1)
- CNT_W, $clog2(DEPTH+1), width of occupancy count (derived; not overridden)

Ports:
- clk  input  1  clock, rising-edge active
- rst  input  1  asynchronous active-high reset
- d  input  WIDTH  input data
- d_valid  input  1  producer has data on d
- d_ready  output  1  pipe accepts d this cycle
- q  output  WIDTH  output data (last stage)
- q_valid  output  1  last stage holds valid data
- q_ready  input  1  consumer accepts q this cycle
- flush  input  1  synchronous clear of all stages
- count  output  CNT_W  number of occupied stages

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (ports clk, rst).
- Reset: while rst=1, all stage valids=0 and all stage data=0, regardless of clk. Outputs: q=0, q_valid=0, count=0, d_ready=1 (if flush=0). Release takes effect at the next rising edge.
- Stage i (0=input side, DEPTH-1=output side) holds data[i] and v[i].
- Stage advance terms:
  - adv[DEPTH-1] = q_ready.
  - adv[i] = !v[i+1] | adv[i+1].
  - rdy[i] = !v[i] | adv[i].
- d_ready = rdy[0] & !flush. It is combinational from q_ready and the valids, with no path from d or d_valid.
- Transfer occurs at the edge when the valid and ready of a boundary are both 1. On a transfer, the downstream stage loads the upstream data and valid.
- A stage that empties with no incoming data clears its valid. Its data holds its last value; data is not cleared on pop.
- Bubble collapsing: an empty stage always accepts from upstream, even when the output is stalled.
- Latency: a word accepted at edge N with an empty pipe appears on q with q_valid=1 after edge N+DEPTH-1, i.e. DEPTH edges to reach the last stage, counting the accepting edge.
- Throughput: one word per cycle when q_ready is held at 1.
- Full: all v=1 and q_ready=0 gives d_ready=0 and no stage changes. With q_ready=1 and the pipe full, d_ready=1: simultaneous pop and push, count unchanged.
- Empty: q_valid=0 and q holds the last output data; the consumer ignores q.
- q_ready with q_valid=0 has no effect.
- flush=1 at an edge:
  - All v cleared; data unchanged; count=0 after the edge.
  - Flush has priority over a simultaneous push and pop; those words are dropped.
  - d_ready=0 during the flush cycle.
- count = popcount(v), combinational from the stage valids, range 0..DEPTH.
- Ordering: strict FIFO; no word is duplicated or lost except by flush or reset.
- Reset mid-stream: all in-flight words are discarded immediately (asynchronous).
- Data stability: q and q_valid are stable while q_valid=1 and q_ready=0.
- DEPTH=1 degenerates to a single register slice, where d_ready = !v[0] | q_ready.

Decomposition:
- Shared package elastic_pkg:
  - function clog2_plus1(n) for CNT_W.
  - localparam defaults for WIDTH=8 and DEPTH=3, reused by benches.
- Sub-module pipe_stage (WIDTH):
  - Ports: clk, rst, flush, in_data, in_valid, out_adv, out_data, out_valid, in_rdy.
  - Instantiated DEPTH times with a generate loop.
- Top-level logic: the adv/rdy chain and the popcount.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with 2 words in flight -> q_valid=0, q=0 and count=0 immediately, before the next edge; after release, d_ready=1.
- Streaming, DEPTH=3, WIDTH=8, q_ready=1: push 0x11,0x22,0x33,0x44 on consecutive edges -> 0x11 valid on q after the 3rd edge, then one word per cycle in order. count stays at 3 in steady state. d_ready=1 throughout.
- Backpressure:
  - Hold q_ready=0 and push 0xA1..0xA4 -> d_ready drops to 0 once count=3; 0xA4 is held at the input and not accepted.
  - Raise q_ready -> 0xA1 pops and 0xA4 is accepted on the same edge; count stays at 3.
- Bubble collapse: push 0x55, idle 1 cycle, push 0x66 with q_ready=0 -> both words occupy the last two stages, count=2. 0x66 is never blocked while a stage is empty.
- Flush: pipe holds 0x01,0x02,0x03; assert flush with d_valid=1 (d=0x04) and q_ready=1 -> d_ready=0 that cycle; after the edge count=0 and q_valid=0. 0x04 never appears on q.
- DEPTH=1 instance: alternate q_ready 1/0 with continuous d_valid (0x10,0x11,...) -> words emerge in order, none lost or duplicated. d_ready = !q_valid | q_ready on every cycle.

Source files
------------

// File: rtl/elastic_pkg.sv
// Shared parameters and helpers for the elastic register pipe.
package elastic_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 3;

  // Width needed to represent the values 0..n inclusive.
  function automatic int clog2_plus1(input int n);
    int w;
    w = 1;
    while ((1 << w) < (n + 1)) w++;
    return w;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One storage slice of the elastic pipe: a data register plus an occupancy bit.
module pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             out_adv,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             in_rdy
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  // Slot can take a word when it is empty or its current word is leaving.
  assign in_rdy    = !r_valid | out_adv;
  assign out_data  = r_data;
  assign out_valid = r_valid;

  // Occupancy: flush wins; otherwise refill (or empty) whenever the slot is free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_valid <= 1'b0;
    else if (flush)  r_valid <= 1'b0;
    else if (in_rdy) r_valid <= in_valid;
  end

  // Data only loads on a real transfer; a popped slot keeps its stale value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              r_data <= '0;
    else if (!flush && in_rdy && in_valid) r_data <= in_data;
  end

endmodule

// File: rtl/elastic_reg_pipe.sv
// DEPTH-stage valid/ready register pipe with bubble collapsing, flush and occupancy count.
module elastic_reg_pipe
  import elastic_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int CNT_W = clog2_plus1(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic             d_ready,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  input  logic             flush,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH-1:0][WIDTH-1:0] w_data;
  logic [DEPTH-1:0]            w_v;
  logic [DEPTH-1:0]            w_adv;
  logic [DEPTH-1:0]            w_rdy;

  // Advance chain from the output back: a stage may move if the next one is free or moving.
  always_comb begin
    logic w_next;
    w_adv  = '0;
    w_rdy  = '0;
    w_next = q_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_adv[i] = w_next;
      w_rdy[i] = !w_v[i] | w_next;
      w_next   = w_rdy[i];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] w_in_data;
      logic             w_in_valid;
      if (gi == 0) begin : g_head
        assign w_in_data  = d;
        assign w_in_valid = d_valid;
      end else begin : g_body
        assign w_in_data  = w_data[gi-1];
        assign w_in_valid = w_v[gi-1];
      end
      pipe_stage #(.WIDTH(WIDTH)) u_stage (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_data  (w_in_data),
        .in_valid (w_in_valid),
        .out_adv  (w_adv[gi]),
        .out_data (w_data[gi]),
        .out_valid(w_v[gi]),
        .in_rdy   (w_rdy[gi])
      );
    end
  endgenerate

  assign d_ready = w_rdy[0] & !flush;
  assign q       = w_data[DEPTH-1];
  assign q_valid = w_v[DEPTH-1];

  // Occupancy is the population count of the stage valids.
  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) count = count + CNT_W'(w_v[i]);
  end

endmodule

// File: tb/tb_elastic_reg_pipe.sv
// Directed bench for elastic_reg_pipe: vector table on a DEPTH=3 pipe plus
// hand sequences for async reset and a DEPTH=1 register slice.
module tb_elastic_reg_pipe;
  import elastic_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  // DEPTH=3 instance
  logic [7:0] d, q;
  logic       d_valid, d_ready, q_valid, q_ready, flush;
  logic [1:0] count;
  // DEPTH=1 instance
  logic [7:0] d1, q1;
  logic       d_valid1, d_ready1, q_valid1, q_ready1, flush1;
  logic       count1;

  int n_total = 0;
  int n_pass  = 0;

  elastic_reg_pipe #(.WIDTH(DEF_WIDTH), .DEPTH(DEF_DEPTH)) dut (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .d_ready(d_ready),
    .q(q), .q_valid(q_valid), .q_ready(q_ready), .flush(flush), .count(count)
  );

  elastic_reg_pipe #(.WIDTH(8), .DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .d(d1), .d_valid(d_valid1), .d_ready(d_ready1),
    .q(q1), .q_valid(q_valid1), .q_ready(q_ready1), .flush(flush1), .count(count1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [2:0] ctl;   // {d_valid, q_ready, flush}
    logic [7:0] eq;
    logic       eqv;
    logic [1:0] ecnt;
    logic       erdy;
  } vec_t;

  vec_t vq[$];

  task automatic v(input logic [7:0] dd, input logic [2:0] ctl, input logic [7:0] eq,
                   input logic eqv, input logic [1:0] ecnt, input logic erdy);
    vec_t t;
    t.d = dd; t.ctl = ctl; t.eq = eq; t.eqv = eqv; t.ecnt = ecnt; t.erdy = erdy;
    vq.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  initial begin
    logic [7:0] exp_out, nxt;
    logic       mv;

    rst = 1'b1;
    d = '0; d_valid = 1'b0; q_ready = 1'b0; flush = 1'b0;
    d1 = '0; d_valid1 = 1'b0; q_ready1 = 1'b0; flush1 = 1'b0;

    // Expected outputs are observed before the edge, with that row's inputs applied.
    // Streaming
    v(8'h11, 3'b110, 8'h00, 1'b0, 2'd0, 1'b1);
    v(8'h22, 3'b110, 8'h00, 1'b0, 2'd1, 1'b1);
    v(8'h33, 3'b110, 8'h00, 1'b0, 2'd2, 1'b1);
    v(8'h44, 3'b110, 8'h11, 1'b1, 2'd3, 1'b1);
    v(8'h00, 3'b010, 8'h22, 1'b1, 2'd3, 1'b1);
    v(8'h00, 3'b010, 8'h33, 1'b1, 2'd2, 1'b1);
    v(8'h00, 3'b010, 8'h44, 1'b1, 2'd1, 1'b1);
    v(8'h00, 3'b010, 8'h44, 1'b0, 2'd0, 1'b1);
    // Backpressure
    v(8'hA1, 3'b100, 8'h44, 1'b0, 2'd0, 1'b1);
    v(8'hA2, 3'b100, 8'h44, 1'b0, 2'd1, 1'b1);
    v(8'hA3, 3'b100, 8'h44, 1'b0, 2'd2, 1'b1);
    v(8'hA4, 3'b100, 8'hA1, 1'b1, 2'd3, 1'b0);
    v(8'hA4, 3'b100, 8'hA1, 1'b1, 2'd3, 1'b0);
    v(8'hA4, 3'b110, 8'hA1, 1'b1, 2'd3, 1'b1);
    v(8'h00, 3'b010, 8'hA2, 1'b1, 2'd3, 1'b1);
    v(8'h00, 3'b010, 8'hA3, 1'b1, 2'd2, 1'b1);
    v(8'h00, 3'b010, 8'hA4, 1'b1, 2'd1, 1'b1);
    v(8'h00, 3'b010, 8'hA4, 1'b0, 2'd0, 1'b1);
    // Bubble collapse
    v(8'h55, 3'b100, 8'hA4, 1'b0, 2'd0, 1'b1);
    v(8'h00, 3'b000, 8'hA4, 1'b0, 2'd1, 1'b1);
    v(8'h66, 3'b100, 8'hA4, 1'b0, 2'd1, 1'b1);
    v(8'h00, 3'b000, 8'h55, 1'b1, 2'd2, 1'b1);
    v(8'h00, 3'b000, 8'h55, 1'b1, 2'd2, 1'b1);
    v(8'h00, 3'b010, 8'h55, 1'b1, 2'd2, 1'b1);
    v(8'h00, 3'b010, 8'h66, 1'b1, 2'd1, 1'b1);
    v(8'h00, 3'b010, 8'h66, 1'b0, 2'd0, 1'b1);
    // Flush
    v(8'h01, 3'b100, 8'h66, 1'b0, 2'd0, 1'b1);
    v(8'h02, 3'b100, 8'h66, 1'b0, 2'd1, 1'b1);
    v(8'h03, 3'b100, 8'h66, 1'b0, 2'd2, 1'b1);
    v(8'h04, 3'b111, 8'h01, 1'b1, 2'd3, 1'b0);
    v(8'h00, 3'b010, 8'h01, 1'b0, 2'd0, 1'b1);
    v(8'h00, 3'b010, 8'h01, 1'b0, 2'd0, 1'b1);

    // Reset state
    #2;
    check("rst_q", q, 8'h00);
    check("rst_qv", q_valid, 1'b0);
    check("rst_cnt", count, 2'd0);
    check("rst_drdy", d_ready, 1'b1);
    check("rst_qv1", q_valid1, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Table
    foreach (vq[k]) begin
      @(negedge clk);
      d = vq[k].d;
      {d_valid, q_ready, flush} = vq[k].ctl;
      #1;
      check($sformatf("v%0d_q", k), q, vq[k].eq);
      check($sformatf("v%0d_qv", k), q_valid, vq[k].eqv);
      check($sformatf("v%0d_cnt", k), count, vq[k].ecnt);
      check($sformatf("v%0d_drdy", k), d_ready, vq[k].erdy);
    end

    // Async reset with two words in flight
    @(negedge clk); d = 8'h77; d_valid = 1'b1; q_ready = 1'b0; flush = 1'b0;
    @(negedge clk); d = 8'h78;
    @(negedge clk); d_valid = 1'b0;
    #1;
    check("inflight_cnt", count, 2'd2);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_qv", q_valid, 1'b0);
    check("arst_q", q, 8'h00);
    check("arst_cnt", count, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_drdy", d_ready, 1'b1);
    check("rel_cnt", count, 2'd0);

    // DEPTH=1 slice: continuous producer, alternating consumer
    mv = 1'b0; nxt = 8'h10; exp_out = 8'h10;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      d1 = nxt; d_valid1 = 1'b1; q_ready1 = (c % 2 == 0);
      #1;
      check($sformatf("d1_c%0d_qv", c), q_valid1, mv);
      check($sformatf("d1_c%0d_drdy", c), d_ready1, !mv | q_ready1);
      check($sformatf("d1_c%0d_cnt", c), count1, mv);
      if (mv) check($sformatf("d1_c%0d_q", c), q1, exp_out);
      if (mv && q_ready1) exp_out = exp_out + 8'd1;
      if (!mv || q_ready1) begin
        mv  = 1'b1;
        nxt = nxt + 8'd1;
      end
    end
    @(negedge clk);
    d_valid1 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
